// File: rtl/viterbi_buffer_sched_if.sv
// Handshake bundle between the Viterbi output-buffer sequencer, the decoder,
// the bit buffer and the downstream consumer.
interface viterbi_buffer_sched_if #(
  parameter int AD = 13
);
  logic          frame_start;
  logic [AD-1:0] frame_len;
  logic          dec_valid;
  logic          dec_bit;
  logic          out_ready;
  logic          buf_rst_n;
  logic          buf_we;
  logic          buf_data;
  logic          buf_re;
  logic [AD-1:0] buf_max_read_address;
  logic          buf_valid_out;
  logic          busy;
  logic          done;
  logic          overflow_err;
  logic          timeout_err;

  modport master (
    output frame_start, frame_len, dec_valid, dec_bit, out_ready, buf_valid_out,
    input  buf_rst_n, buf_we, buf_data, buf_re, buf_max_read_address,
           busy, done, overflow_err, timeout_err
  );

  modport slave (
    input  frame_start, frame_len, dec_valid, dec_bit, out_ready, buf_valid_out,
    output buf_rst_n, buf_we, buf_data, buf_re, buf_max_read_address,
           busy, done, overflow_err, timeout_err
  );
endinterface

// File: rtl/viterbi_buffer_sched.sv
// Frame sequencer for the Viterbi output bit buffer: clears it, gates writes,
// holds reads until a fill threshold, streams under backpressure, reports end of frame.
module viterbi_buffer_sched #(
  parameter int AD     = 13,
  parameter int THRESH = 64,
  parameter int WDOG   = 1024
) (
  input logic                  clk,
  input logic                  reset,
  viterbi_buffer_sched_if.slave bus
);
  localparam int WW = $clog2(WDOG + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FILL, STREAM, DRAIN, FINISH} state_t;

  state_t        state, state_n;
  logic [AD-1:0] len_q, len_n;
  logic [AD-1:0] wr_cnt, wr_cnt_n, wr_inc;
  logic [AD-1:0] rd_cnt, rd_cnt_n, rd_inc;
  logic [AD-1:0] max_addr_n;
  logic [WW-1:0] wdog, wdog_n;
  logic          in_wr, in_rd, rd_fin, wd_fire, to_fin, accept, reject;
  logic          we_n, data_n, re_n, ovf_n, tmo_n;

  always_comb begin
    state_n    = state;
    len_n      = len_q;
    rd_cnt_n   = rd_cnt;
    wdog_n     = wdog;
    max_addr_n = bus.buf_max_read_address;
    ovf_n      = bus.overflow_err;
    tmo_n      = bus.timeout_err;

    in_wr   = (state == CLEAR) || (state == FILL) || (state == STREAM);
    in_rd   = (state == STREAM) || (state == DRAIN);
    rd_inc  = rd_cnt + AD'(in_rd && bus.buf_valid_out);
    rd_fin  = in_rd && (rd_inc == len_q);
    wd_fire = in_rd && bus.buf_re && !bus.buf_valid_out && (wdog == WW'(WDOG - 1));
    to_fin  = rd_fin || wd_fire;

    // A bit arriving on the abort cycle is dropped so FINISH never shows a write.
    accept  = in_wr && bus.dec_valid && (wr_cnt != len_q) && !to_fin;
    reject  = (in_wr || (state == DRAIN)) && bus.dec_valid && (wr_cnt == len_q);
    wr_inc  = wr_cnt + AD'(accept);
    wr_cnt_n = wr_inc;

    we_n   = accept;
    data_n = accept & bus.dec_bit;
    re_n   = in_rd && !to_fin && bus.out_ready;

    if (in_rd) begin
      rd_cnt_n = rd_inc;
      if (bus.buf_valid_out) wdog_n = '0;
      else if (bus.buf_re)   wdog_n = wdog + WW'(1);
    end
    if (reject)  ovf_n = 1'b1;
    if (wd_fire) tmo_n = 1'b1;

    case (state)
      IDLE: begin
        if (bus.frame_start) begin
          if (bus.frame_len != '0) begin
            len_n      = bus.frame_len;
            max_addr_n = bus.frame_len - AD'(1);
            wr_cnt_n   = '0;
            rd_cnt_n   = '0;
            wdog_n     = '0;
            ovf_n      = 1'b0;
            tmo_n      = 1'b0;
            state_n    = CLEAR;
          end else begin
            state_n = FINISH;
          end
        end
      end
      CLEAR:  state_n = FILL;
      FILL:   if ((wr_inc >= AD'(THRESH)) || (wr_inc == len_q)) state_n = STREAM;
      STREAM: begin
        if (to_fin)                state_n = FINISH;
        else if (wr_inc == len_q)  state_n = DRAIN;
      end
      DRAIN:  if (to_fin) state_n = FINISH;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered state, counters and every output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                    <= IDLE;
      len_q                    <= '0;
      wr_cnt                   <= '0;
      rd_cnt                   <= '0;
      wdog                     <= '0;
      bus.buf_rst_n            <= 1'b0;
      bus.buf_we               <= 1'b0;
      bus.buf_data             <= 1'b0;
      bus.buf_re               <= 1'b0;
      bus.buf_max_read_address <= '0;
      bus.busy                 <= 1'b0;
      bus.done                 <= 1'b0;
      bus.overflow_err         <= 1'b0;
      bus.timeout_err          <= 1'b0;
    end else begin
      state                    <= state_n;
      len_q                    <= len_n;
      wr_cnt                   <= wr_cnt_n;
      rd_cnt                   <= rd_cnt_n;
      wdog                     <= wdog_n;
      bus.buf_rst_n            <= (state_n != CLEAR);
      bus.buf_we               <= we_n;
      bus.buf_data             <= data_n;
      bus.buf_re               <= re_n;
      bus.buf_max_read_address <= max_addr_n;
      bus.busy                 <= (state_n != IDLE);
      bus.done                 <= (state_n == FINISH);
      bus.overflow_err         <= ovf_n;
      bus.timeout_err          <= tmo_n;
    end
  end
endmodule

// File: tb/tb_viterbi_buffer_sched.sv
// Randomised bench for viterbi_buffer_sched: a frame-level reference model predicts
// every registered output each cycle; directed frames pin the key timing points.
module tb_viterbi_buffer_sched;
  localparam int AD     = 13;
  localparam int THRESH = 64;
  localparam int WDOG   = 16;

  logic clk;
  logic reset;
  viterbi_buffer_sched_if #(.AD(AD)) bus ();

  viterbi_buffer_sched #(.AD(AD), .THRESH(THRESH), .WDOG(WDOG)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: a frame is either idle, finishing, or active; an active frame
  // has a one-cycle clear, then accepts bits up to len and reads once enough are in.
  bit            m_active, m_clear, m_reading, m_fin;
  int            m_len, m_wr, m_rd, m_wd;
  logic          e_rstn, e_we, e_data, e_re, e_busy, e_done, e_ovf, e_tmo;
  logic [AD-1:0] e_max;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_active = 0; m_clear = 0; m_reading = 0; m_fin = 0;
      m_len = 0; m_wr = 0; m_rd = 0; m_wd = 0;
      e_rstn = 0; e_we = 0; e_data = 0; e_re = 0; e_busy = 0; e_done = 0;
      e_ovf = 0; e_tmo = 0; e_max = '0;
    end else if (m_fin) begin
      m_fin = 0;
      e_done = 0; e_busy = 0; e_rstn = 1; e_we = 0; e_re = 0;
    end else if (!m_active) begin
      e_we = 0; e_re = 0; e_done = 0; e_rstn = 1; e_busy = 0;
      if (bus.frame_start) begin
        if (bus.frame_len != 0) begin
          m_active = 1; m_clear = 1; m_reading = 0;
          m_len = int'(bus.frame_len); m_wr = 0; m_rd = 0; m_wd = 0;
          e_ovf = 0; e_tmo = 0; e_max = bus.frame_len - AD'(1);
          e_rstn = 0; e_busy = 1;
        end else begin
          m_fin = 1; e_done = 1; e_busy = 1;
        end
      end
    end else begin
      bit rd_end, wd_end, fin, acc;
      rd_end = m_reading && (m_rd + int'(bus.buf_valid_out) == m_len);
      wd_end = m_reading && e_re && !bus.buf_valid_out && (m_wd == WDOG - 1);
      fin    = rd_end || wd_end;
      acc    = bus.dec_valid && (m_wr < m_len) && !fin;
      if (bus.dec_valid && m_wr == m_len) e_ovf = 1;
      e_we = acc; e_data = bus.dec_bit;
      m_wr = m_wr + int'(acc);
      if (m_reading) begin
        m_rd = m_rd + int'(bus.buf_valid_out);
        if (bus.buf_valid_out) m_wd = 0;
        else if (e_re)         m_wd = m_wd + 1;
      end
      e_re = m_reading && !fin && bus.out_ready;
      e_rstn = 1; e_busy = 1; e_done = 0;
      if (fin) begin
        m_active = 0; m_reading = 0; m_fin = 1; e_done = 1;
        if (wd_end) e_tmo = 1;
      end else if (m_clear) begin
        m_clear = 0;
      end else if (!m_reading && (m_wr >= THRESH || m_wr == m_len)) begin
        m_reading = 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    tests++;
    if ({bus.buf_rst_n, bus.buf_we, bus.buf_re, bus.busy, bus.done, bus.overflow_err,
         bus.timeout_err, bus.buf_max_read_address} !==
        {e_rstn, e_we, e_re, e_busy, e_done, e_ovf, e_tmo, e_max} ||
        (e_we && bus.buf_data !== e_data)) begin
      fails++;
      if (fails <= 20)
        $display("FAIL cycle_compare @%0d: got rstn=%b we=%b data=%b re=%b max=%0d busy=%b done=%b ovf=%b tmo=%b, expected rstn=%b we=%b data=%b re=%b max=%0d busy=%b done=%b ovf=%b tmo=%b",
                 cyc, bus.buf_rst_n, bus.buf_we, bus.buf_data, bus.buf_re, bus.buf_max_read_address,
                 bus.busy, bus.done, bus.overflow_err, bus.timeout_err,
                 e_rstn, e_we, e_data, e_re, e_max, e_busy, e_done, e_ovf, e_tmo);
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation time limit reached, expected normal completion");
    $fatal(1, "time limit");
  end

  // Stimulus state and per-frame observations
  int nbits_left = 0, dv_pct = 100, or_mode = 0, bmode = 0;
  int bwr = 0, breq = 0;
  bit next_bvo = 0;
  int n_we, n_bvo, n_done, n_strobe, first_re, rstn_lo, ovf_first, done_cyc;
  int we_mark_cyc, mark_we, strobe_mark, str_cyc, start_cyc, ovf_after_start;
  logic ovf_at_done, tmo_at_done;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    bus.dec_valid = 1'b0;
    if (nbits_left > 0 && int'($urandom_range(99)) < dv_pct) begin
      bus.dec_valid = 1'b1;
      nbits_left--;
      n_strobe++;
      if (n_strobe == strobe_mark) str_cyc = cyc + 1;
    end
    bus.dec_bit = 1'($urandom_range(1));
    case (or_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ((cyc / 3) % 2 == 0);
      default: bus.out_ready = 1'($urandom_range(1));
    endcase
    // Buffer stand-in: one-cycle read latency, never returns more bits than were written
    bus.buf_valid_out = next_bvo;
    if (next_bvo) n_bvo++;
    next_bvo = 1'b0;
    if (bmode != 2 && bus.buf_re && breq < bwr && (bmode == 0 || $urandom_range(3) != 0)) begin
      next_bvo = 1'b1;
      breq++;
    end
    @(negedge clk);
    cyc++;
    if (bus.buf_we) begin
      bwr++; n_we++;
      if (n_we == mark_we) we_mark_cyc = cyc;
    end
    if (bus.buf_re && first_re < 0) first_re = cyc;
    if (!bus.buf_rst_n && rstn_lo < 0) rstn_lo = cyc;
    if (bus.overflow_err && ovf_first < 0) ovf_first = cyc;
    if (bus.done) begin
      n_done++; done_cyc = cyc;
      ovf_at_done = bus.overflow_err; tmo_at_done = bus.timeout_err;
    end
  endtask

  task automatic start_frame(int len, int nbits, int dvp, int orm, int bm);
    n_we = 0; n_bvo = 0; n_done = 0; n_strobe = 0; first_re = -1; rstn_lo = -1;
    ovf_first = -1; done_cyc = -1; we_mark_cyc = -1; str_cyc = -1;
    mark_we = (len < THRESH) ? len : THRESH;
    strobe_mark = len + 1;
    dv_pct = dvp; or_mode = orm; bmode = bm;
    bwr = 0; breq = 0; next_bvo = 0; nbits_left = 0;
    bus.frame_start = 1'b1;
    bus.frame_len = AD'(len);
    start_cyc = cyc;
    tick();
    bus.frame_start = 1'b0;
    ovf_after_start = int'(bus.overflow_err);
    nbits_left = nbits;
  endtask

  task automatic wait_done(bit strays);
    for (int i = 0; i < 8000 && n_done == 0; i++) begin
      if (strays && $urandom_range(99) < 3) begin
        bus.frame_start = 1'b1;
        bus.frame_len = AD'($urandom_range(500));
      end
      tick();
      bus.frame_start = 1'b0;
    end
    check("done_seen", n_done, 1);
    nbits_left = 0;
    tick();
    check("done_single_pulse", n_done, 1);
  endtask

  initial begin
    reset = 1'b0;
    bus.frame_start = 1'b0; bus.frame_len = '0; bus.dec_valid = 1'b0; bus.dec_bit = 1'b0;
    bus.out_ready = 1'b0; bus.buf_valid_out = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({bus.buf_rst_n, bus.buf_we, bus.buf_data, bus.buf_re, bus.busy,
          bus.done, bus.overflow_err, bus.timeout_err, bus.buf_max_read_address}), 0);
    reset = 1'b0;
    tick();
    check("idle_buf_rst_n", int'(bus.buf_rst_n), 1);

    // Long frame, continuous input, no backpressure
    start_frame(200, 200, 100, 0, 0);
    check("clear_one_cycle_after_start", rstn_lo - start_cyc, 1);
    tick();
    check("clear_released", int'(bus.buf_rst_n), 1);
    wait_done(0);
    check("len200_writes", n_we, 200);
    check("len200_reads", n_bvo, 200);
    check("len200_first_re_after_64th_write", first_re - we_mark_cyc, 1);
    check("len200_errors", int'({ovf_at_done, tmo_at_done}), 0);

    // Short frame enters streaming without reaching the threshold
    start_frame(10, 10, 100, 0, 0);
    wait_done(0);
    check("len10_max_addr", int'(bus.buf_max_read_address), 9);
    check("len10_first_re_after_last_write", first_re - we_mark_cyc, 1);
    check("len10_reads", n_bvo, 10);

    // Overflow: five strobes too many
    start_frame(100, 105, 100, 0, 0);
    wait_done(0);
    check("ovf_writes", n_we, 100);
    check("ovf_flag_at_done", int'(ovf_at_done), 1);
    check("ovf_from_101st_strobe", ovf_first - str_cyc, 0);

    // Backpressure toggling every three cycles; new frame clears overflow
    start_frame(300, 300, 100, 1, 0);
    check("ovf_cleared_by_start", ovf_after_start, 0);
    wait_done(0);
    check("toggle_reads", n_bvo, 300);
    check("toggle_no_timeout", int'(tmo_at_done), 0);

    // Buffer never answers: watchdog abort
    start_frame(100, 100, 100, 0, 2);
    wait_done(0);
    check("wdog_timeout_flag", int'(tmo_at_done), 1);
    check("wdog_cycles", done_cyc - first_re, WDOG);
    check("wdog_no_reads", n_bvo, 0);

    // Zero-length frame
    start_frame(0, 0, 100, 0, 0);
    check("len0_done_latency", done_cyc - start_cyc, 1);
    wait_done(0);
    check("len0_no_writes", n_we, 0);

    // Reset in the middle of streaming
    start_frame(200, 200, 100, 0, 0);
    repeat (85) tick();
    check("midreset_no_done_before", n_done, 0);
    #2 reset = 1'b1;
    bus.dec_valid = 1'b0;
    #1 check("midreset_outputs_async", int'({bus.buf_rst_n, bus.buf_we, bus.buf_data, bus.buf_re,
          bus.busy, bus.done, bus.overflow_err, bus.timeout_err, bus.buf_max_read_address}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bwr = 0; breq = 0; next_bvo = 0; nbits_left = 0;
    tick();
    start_frame(50, 50, 100, 0, 0);
    wait_done(0);
    check("after_reset_writes", n_we, 50);
    check("after_reset_reads", n_bvo, 50);

    // Randomised frames with stray frame_start pulses while busy
    for (int f = 0; f < 12; f++) begin
      int len, extra;
      len = int'($urandom_range(400, 1));
      extra = ($urandom_range(3) == 0) ? int'($urandom_range(8, 1)) : 0;
      start_frame(len, len + extra, int'($urandom_range(100, 70)), int'($urandom_range(2)),
                  int'($urandom_range(1)));
      wait_done(1);
      repeat (int'($urandom_range(3))) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
